// File: rtl/layer0_input_packer.sv
// Stream-to-vector front end for the layer0 neuron LUTs: quantizes signed samples and packs
// NUM_FEAT of them into a double-buffered, held output frame. Optional macro: LAYER0_PACKER_TLAST_EN.
module layer0_input_packer #(
    parameter int IN_W     = 12,
    parameter int Q_BITS   = 2,
    parameter int NUM_FEAT = 16,
    parameter int SHIFT    = 9,
    parameter int OFFSET   = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic signed [IN_W-1:0]       s_data,
`ifdef LAYER0_PACKER_TLAST_EN
    input  logic                         s_last,
    output logic                         frame_err,
`endif
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [NUM_FEAT*Q_BITS-1:0]   m_data,
    output logic [15:0]                  frame_cnt
);

    localparam int OUT_W = NUM_FEAT * Q_BITS;
    localparam int IDX_W = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1;
    localparam int T_W   = IN_W + 2;

    localparam logic [0:0] ST_FILL  = 1'b0;
    localparam logic [0:0] ST_STALL = 1'b1;

    localparam logic signed [T_W-1:0] Q_MAX_T = T_W'((1 << Q_BITS) - 1);
    localparam logic signed [T_W-1:0] OFS_T   = T_W'(OFFSET);
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_FEAT - 1);

    logic [0:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [OUT_W-1:0] collect_q, collect_d;
    logic [OUT_W-1:0] m_data_q, m_data_d;
    logic             m_valid_q, m_valid_d;
    logic             s_ready_q, s_ready_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;
    logic             err_q, err_d;

    logic signed [T_W-1:0] ext_s, t_s;
    logic [Q_BITS-1:0]     q;
    logic [OUT_W-1:0]      collect_ins;
    logic                  accept, drain, at_last, frame_done;

    // Quantizer: sign-extend first so the shift and offset cannot overflow.
    always_comb begin
        ext_s = {{2{s_data[IN_W-1]}}, s_data};
        t_s   = (ext_s >>> SHIFT) + OFS_T;
        if (t_s[T_W-1]) begin
            q = '0;
        end else if (t_s > Q_MAX_T) begin
            q = '1;
        end else begin
            q = t_s[Q_BITS-1:0];
        end
    end

    assign accept  = s_valid && s_ready_q;
    assign drain   = m_valid_q && m_ready;
    assign at_last = (idx_q == IDX_LAST);

`ifdef LAYER0_PACKER_TLAST_EN
    assign frame_done = at_last || s_last;
    assign err_d      = accept && (s_last != at_last);
`else
    assign frame_done = at_last;
    assign err_d      = 1'b0;
`endif

    always_comb begin
        collect_ins = collect_q;
        collect_ins[idx_q*Q_BITS +: Q_BITS] = q;
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        collect_d   = collect_q;
        m_data_d    = m_data_q;
        m_valid_d   = m_valid_q;
        frame_cnt_d = frame_cnt_q;

        if (drain) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
            m_valid_d   = 1'b0;
        end

        if (state_q == ST_STALL) begin
            if (drain) begin
                m_data_d  = collect_q;
                m_valid_d = 1'b1;
                collect_d = '0;
                state_d   = ST_FILL;
            end
        end else if (accept) begin
            if (frame_done) begin
                idx_d = '0;
                // collect is cleared at every frame start, so a short frame is zero-filled for free
                if (!m_valid_q || m_ready) begin
                    m_data_d  = collect_ins;
                    m_valid_d = 1'b1;
                    collect_d = '0;
                end else begin
                    collect_d = collect_ins;
                    state_d   = ST_STALL;
                end
            end else begin
                collect_d = collect_ins;
                idx_d     = idx_q + IDX_W'(1);
            end
        end

        s_ready_d = (state_d == ST_FILL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_FILL;
            idx_q       <= '0;
            collect_q   <= '0;
            m_data_q    <= '0;
            m_valid_q   <= 1'b0;
            s_ready_q   <= 1'b1;
            frame_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            collect_q   <= collect_d;
            m_data_q    <= m_data_d;
            m_valid_q   <= m_valid_d;
            s_ready_q   <= s_ready_d;
            frame_cnt_q <= frame_cnt_d;
            err_q       <= err_d;
        end
    end

    assign s_ready   = s_ready_q;
    assign m_valid   = m_valid_q;
    assign m_data    = m_data_q;
    assign frame_cnt = frame_cnt_q;

`ifdef LAYER0_PACKER_TLAST_EN
    assign frame_err = err_q;
`else
    logic unused_err;
    assign unused_err = err_q;
`endif

endmodule

// File: tb/tb_layer0_input_packer.sv
// Directed bench for layer0_input_packer: a frame-level model plus literal frame checks.
module tb_layer0_input_packer;

    localparam int NF = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [11:0] s_data = '0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [31:0] m_data;
    logic [15:0] frame_cnt;
`ifdef LAYER0_PACKER_TLAST_EN
    logic        s_last = 1'b0;
    logic        frame_err;
`endif

    always #5 clk = ~clk;

    layer0_input_packer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
`ifdef LAYER0_PACKER_TLAST_EN
        .s_last    (s_last),
        .frame_err (frame_err),
`endif
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .frame_cnt (frame_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Quantizer from the arithmetic definition: floor(s/512) + 2, clamped to 0..3.
    function automatic int quant(input int s);
        int f;
        f = (s >= 0) ? (s / 512) : -((-s + 511) / 512);
        f = f + 2;
        if (f < 0) f = 0;
        if (f > 3) f = 3;
        return f;
    endfunction

    // Model: partial frame under construction and a queue of completed, undelivered frames.
    logic [31:0] part_vec;
    int          part_n;
    logic [31:0] pend[$];
    logic [31:0] got[$];
    logic [15:0] exp_cnt;
    bit          exp_err;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            part_vec = '0;
            part_n   = 0;
            pend.delete();
            got.delete();
            exp_cnt  = '0;
            exp_err  = 1'b0;
        end else begin
            bit last_flag;
            bit done;
            exp_err = 1'b0;
            if (m_valid && m_ready) begin
                got.push_back(m_data);
                if (pend.size() > 0) void'(pend.pop_front());
                exp_cnt = exp_cnt + 16'd1;
            end
            if (s_valid && s_ready) begin
                last_flag = (part_n == NF - 1);
                done      = last_flag;
`ifdef LAYER0_PACKER_TLAST_EN
                exp_err = (s_last != last_flag);
                done    = last_flag || s_last;
`endif
                part_vec = part_vec | (32'(quant(int'($signed(s_data)))) << (2 * part_n));
                part_n++;
                if (done) begin
                    pend.push_back(part_vec);
                    part_vec = '0;
                    part_n   = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("m_valid", 32'(m_valid), 32'(pend.size() > 0));
            check("s_ready", 32'(s_ready), 32'(pend.size() < 2));
            check("frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
            if (pend.size() > 0) check("m_data", m_data, pend[0]);
`ifdef LAYER0_PACKER_TLAST_EN
            check("frame_err", 32'(frame_err), 32'(exp_err));
`endif
        end
    end

    // Called just after a falling edge; returns on the falling edge after the accepting edge.
    task automatic send(input int v, input bit last);
        int guard;
        guard = 0;
        s_valid = 1'b1;
        s_data  = 12'(v);
`ifdef LAYER0_PACKER_TLAST_EN
        s_last  = last;
`endif
        while (!s_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: got s_ready=0 for %0d cycles expected 1", guard);
        end
        @(negedge clk);
`ifdef LAYER0_PACKER_TLAST_EN
        s_last = 1'b0;
`endif
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_state();
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data", m_data, 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("rst_s_ready", 32'(s_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish by 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        int sweep[6];
        sweep = '{-2048, -1, 0, 511, 600, 2047};

        repeat (3) @(negedge clk);
        check_reset_state();
        rst_n = 1'b1;
        @(negedge clk);
        $display("reset released");

        // Quantizer sweep followed by zeros (q=2) to complete the frame
        m_ready = 1'b1;
        for (int i = 0; i < 6; i++) send(sweep[i], 1'b0);
        for (int i = 0; i < 10; i++) send(0, 1'b0);
        check("sweep_valid", 32'(m_valid), 32'd1);
        check("sweep_frame", m_data, 32'hAAAAAFA4);
        $display("frame sweep: m_data=%h", m_data);
        idle(2);

        // 16 x 600, back-to-back
        for (int i = 0; i < NF; i++) send(600, 1'b0);
        check("sat_valid", 32'(m_valid), 32'd1);
        check("sat_frame", m_data, 32'hFFFFFFFF);
        $display("frame saturate: m_data=%h", m_data);
        idle(2);
        check("sat_cnt", 32'(frame_cnt), 32'd2);
        check("sat_drop", 32'(m_valid), 32'd0);

        // Ordering: feature k carries k%4
        for (int k = 0; k < NF; k++) send(((k % 4) - 2) * 512, 1'b0);
        check("order_frame", m_data, 32'hE4E4E4E4);
        $display("frame order: m_data=%h", m_data);
        idle(2);

        // Backpressure across two frames
        m_ready = 1'b0;
        for (int i = 0; i < NF; i++) send(0, 1'b0);
        for (int i = 0; i < NF; i++) send(-512, 1'b0);
        s_valid = 1'b0;
        check("bp_s_ready", 32'(s_ready), 32'd0);
        check("bp_hold0", m_data, 32'hAAAAAAAA);
        idle(3);
        check("bp_hold1", m_data, 32'hAAAAAAAA);
        check("bp_valid", 32'(m_valid), 32'd1);
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        check("bp_second", m_data, 32'h55555555);
        check("bp_valid2", 32'(m_valid), 32'd1);
        check("bp_ready2", 32'(s_ready), 32'd1);
        $display("frame backpressure: m_data=%h", m_data);
        m_ready = 1'b1;
        idle(2);
        check("bp_drain", 32'(m_valid), 32'd0);
        check("bp_cnt", 32'(frame_cnt), 32'd5);

        // Reset mid-frame
        for (int i = 0; i < 7; i++) send(600, 1'b0);
        s_valid = 1'b0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        check_reset_state();
        rst_n = 1'b1;
        for (int i = 0; i < NF; i++) send(0, 1'b0);
        idle(2);
        check("rst_frames", 32'(got.size()), 32'd1);
        if (got.size() > 0) check("rst_frame", got[0], 32'hAAAAAAAA);
        check("rst_cnt", 32'(frame_cnt), 32'd1);
        $display("frame after reset: frames=%0d cnt=%0d", got.size(), frame_cnt);

`ifdef LAYER0_PACKER_TLAST_EN
        for (int i = 0; i < 3; i++) send(2047, 1'b0);
        send(2047, 1'b1);
        check("tlast_frame", m_data, 32'h000000FF);
        check("tlast_err", 32'(frame_err), 32'd1);
        idle(1);
        check("tlast_err_drop", 32'(frame_err), 32'd0);
        $display("frame tlast: m_data=%h", got.size() > 0 ? got[got.size()-1] : 32'd0);
        idle(2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/layer0_input_packer.md
Name: layer0_input_packer

Overview:
- Stream-to-vector front end that sits directly upstream of the layer0 neuron LUTs in the readout classifier.
- Accepts one signed ADC feature sample per handshake and quantizes each to Q_BITS bits.
- Packs NUM_FEAT quantized features into one flat vector.
- Presents the vector, registered and held, to the layer0 fan-in through a valid/ready handshake.
- Double-buffered: the next frame can fill while the previous one waits for the downstream consumer.

Parameters:
- IN_W, 12, width of signed input sample.
- Q_BITS, 2, bits per quantized feature.
- NUM_FEAT, 16, features per frame. Output width is NUM_FEAT*Q_BITS.
- SHIFT, 9, arithmetic right shift applied before offset.
- OFFSET, 2, signed offset added after the shift.

Ports:
- clk, input, 1, single clock; all logic is rising-edge.
- rst_n, input, 1, asynchronous active-low reset.
- s_valid, input, 1, input sample valid.
- s_ready, output, 1, packer can accept a sample.
- s_data, input, IN_W, signed two's-complement sample.
- m_valid, output, 1, packed frame valid.
- m_ready, input, 1, downstream accepts the frame.
- m_data, output, NUM_FEAT*Q_BITS, packed quantized features.
- frame_cnt, output, 16, count of frames delivered; wraps at 65535 to 0.

Behaviour:
- Reset (async assert, sync release):
  - m_valid=0, m_data=0, frame_cnt=0, fill index=0, collect buffer=0, s_ready=1.
  - Assertion mid-frame discards the partial frame and any held output.
- Quantize (combinational on s_data):
  - t = (s_data >>> SHIFT) + OFFSET, computed signed at IN_W+2 bits.
  - q = 0 if t<0; (2^Q_BITS-1) if t>2^Q_BITS-1; else t.
- Input accept:
  - A sample is accepted when s_valid && s_ready.
  - q is written to collect[idx*Q_BITS +: Q_BITS]. The first sample of a frame is feature 0 (LSBs).
  - idx increments and wraps to 0 after NUM_FEAT-1.
- Transfer:
  - Accepting feature NUM_FEAT-1 while the output register is empty, or is being drained this cycle (m_valid && m_ready), loads m_data from collect plus the new q.
  - m_valid=1 on the next cycle.
  - Latency from the last accepted sample to m_valid is 1 cycle.
- States:
  - FILL: normal collection.
  - STALL: entered when the last feature is accepted while the output is full and not draining. The completed frame is held in collect, and s_ready=0.
  - In STALL, when m_ready && m_valid: m_data<=collect, m_valid stays 1, return to FILL with idx=0.
- s_ready:
  - 1 in FILL. This includes idx=NUM_FEAT-1 with the output full: the sample is taken and the block moves to STALL.
  - 0 in STALL.
  - Registered; does not depend combinationally on m_ready.
- Output:
  - m_data and m_valid are stable while m_valid && !m_ready.
  - On m_valid && m_ready with no refill, m_valid drops the next cycle.
  - frame_cnt increments on each m_valid && m_ready.
- Throughput: with m_ready held high, one frame every NUM_FEAT cycles, no bubbles.
- Simultaneous events: completing the last feature on the same cycle the output drains reloads m_data directly. m_valid stays 1 with no gap cycle.

Optional Feature:
- Macro: LAYER0_PACKER_TLAST_EN.
- Enabled:
  - Adds input port s_last (1 bit) and output port frame_err (1-cycle pulse).
  - s_last accepted with idx<NUM_FEAT-1: remaining features are zero-filled, the frame completes immediately through the normal transfer path, and frame_err pulses.
  - Feature NUM_FEAT-1 accepted without s_last: the frame still completes, and frame_err pulses.
  - frame_err resets to 0.
- Disabled: no s_last or frame_err ports; frames are delimited purely by count.

Test Plan:
- Quantizer sweep, m_ready=1: s_data=-2048, -1, 0, 511, 600, 2047 -> q=0, 1, 2, 2, 3, 3.
- Frame of 16 samples, each s_data=600, m_ready=1 -> m_valid high 1 cycle after the 16th accept, m_data=32'hFFFFFFFF, frame_cnt=1.
- Ordering: feature k = k%4 mapped to s_data=(k%4-2)*512 -> m_data=32'hE4E4E4E4.
- Backpressure: m_ready=0 across two full frames -> s_ready=0 after the 32nd accept. First m_data is held stable. Raise m_ready for 1 cycle -> second frame appears next cycle, s_ready=1.
- Reset after 7 accepted samples, then 16 samples of 0 -> only m_data=32'hAAAAAAAA is produced, frame_cnt=1.
- With LAYER0_PACKER_TLAST_EN: s_last on the 4th sample (all 2047) -> m_data=32'h000000FF, frame_err pulses 1 cycle.
